// File: rtl/main_control_fsm.sv
// Multicycle control FSM for the MIPS-subset CPU.
// Sequences fetch/decode/execute/memory/writeback and drives every datapath
// mux select, write enable and the 2-bit ALUOp to the ALU control decoder.
module main_control_fsm #(
  parameter logic [5:0] OPC_R    = 6'h00,
  parameter logic [5:0] OPC_LW   = 6'h23,
  parameter logic [5:0] OPC_SW   = 6'h2b,
  parameter logic [5:0] OPC_BEQ  = 6'h04,
  parameter logic [5:0] OPC_BNE  = 6'h05,
  parameter logic [5:0] OPC_J    = 6'h02,
  parameter logic [5:0] OPC_ADDI = 6'h08
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic [1:0] ALUOp,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       illegalOp,
  output logic [3:0] stateOut
);

  typedef enum logic [3:0] {
    ST_RESET         = 4'd0,
    ST_FETCH         = 4'd1,
    ST_FETCH_WAIT    = 4'd2,
    ST_DECODE        = 4'd3,
    ST_EXEC_R        = 4'd4,
    ST_WB_R          = 4'd5,
    ST_ADDR_CALC     = 4'd6,
    ST_MEM_READ      = 4'd7,
    ST_MEM_READ_WAIT = 4'd8,
    ST_WB_LW         = 4'd9,
    ST_MEM_WRITE     = 4'd10,
    ST_BRANCH        = 4'd11,
    ST_JUMP          = 4'd12,
    ST_EXEC_ADDI     = 4'd13,
    ST_WB_ADDI       = 4'd14,
    ST_ILLEGAL       = 4'd15
  } state_t;

  state_t state, state_next;
  logic   is_bne_q;   // branch flavour latched in DECODE so BRANCH need not look at opcode
  logic   illegal_q;

  // State register, branch-flavour latch and sticky illegal flag.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RESET;
      is_bne_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_next;
      if (state == ST_DECODE) is_bne_q <= (opcode == OPC_BNE);
      illegal_q <= illegal_q | (state_next == ST_ILLEGAL);
    end
  end

  // Next-state logic; opcode is consulted only in DECODE and ADDR_CALC.
  // NOTE: a default is assigned first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RESET:         state_next = ST_FETCH;
      ST_FETCH:         state_next = ST_FETCH_WAIT;
      ST_FETCH_WAIT:    state_next = ST_DECODE;
      ST_DECODE: begin
        if (opcode == OPC_R)                             state_next = ST_EXEC_R;
        else if (opcode == OPC_LW || opcode == OPC_SW)   state_next = ST_ADDR_CALC;
        else if (opcode == OPC_BEQ || opcode == OPC_BNE) state_next = ST_BRANCH;
        else if (opcode == OPC_J)                        state_next = ST_JUMP;
        else if (opcode == OPC_ADDI)                     state_next = ST_EXEC_ADDI;
        else                                             state_next = ST_ILLEGAL;
      end
      ST_EXEC_R:        state_next = ST_WB_R;
      ST_WB_R:          state_next = ST_FETCH;
      ST_ADDR_CALC:     state_next = (opcode == OPC_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:      state_next = ST_MEM_READ_WAIT;
      ST_MEM_READ_WAIT: state_next = ST_WB_LW;
      ST_WB_LW:         state_next = ST_FETCH;
      ST_MEM_WRITE:     state_next = ST_FETCH;
      ST_BRANCH:        state_next = ST_FETCH;
      ST_JUMP:          state_next = ST_FETCH;
      ST_EXEC_ADDI:     state_next = ST_WB_ADDI;
      ST_WB_ADDI:       state_next = ST_FETCH;
      ST_ILLEGAL:       state_next = ST_ILLEGAL;
      default:          state_next = ST_RESET;
    endcase
  end

  // Per-state outputs, decoded from the registered state (BRANCH PCWrite also uses zero).
  always_comb begin
    ALUOp    = 2'b11;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSource = 2'b00;
    unique case (state)
      ST_FETCH: MemRead = 1'b1;
      ST_FETCH_WAIT: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b00;
        PCWrite = 1'b1;
      end
      ST_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = 2'b00;
      end
      ST_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
      end
      ST_WB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      ST_ADDR_CALC, ST_EXEC_ADDI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b00;
      end
      ST_MEM_READ, ST_MEM_READ_WAIT: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      ST_WB_LW: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      ST_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b10;
        PCSource = 2'b01;
        PCWrite  = is_bne_q ? ~zero : zero;
      end
      ST_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      ST_WB_ADDI: RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign illegalOp = illegal_q;
  assign stateOut  = state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: the stimulus process walks each
// instruction through a reference model of its state sequence and pushes the
// expected state/outputs per cycle; the monitor pops and compares on every
// falling edge.
module tb_main_control_fsm;

  localparam logic [5:0] OPC_R    = 6'h00;
  localparam logic [5:0] OPC_LW   = 6'h23;
  localparam logic [5:0] OPC_SW   = 6'h2b;
  localparam logic [5:0] OPC_BEQ  = 6'h04;
  localparam logic [5:0] OPC_BNE  = 6'h05;
  localparam logic [5:0] OPC_J    = 6'h02;
  localparam logic [5:0] OPC_ADDI = 6'h08;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       illegal;
  } out_t;

  typedef struct packed {
    logic [3:0] st;
    out_t       o;
  } rec_t;

  typedef int iq_t[$];

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       zero;
  logic [1:0] ALUOp;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic       RegDst, MemToReg, ALUSrcA, illegalOp;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] stateOut;

  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t sb[$];

  main_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .ALUOp(ALUOp), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .illegalOp(illegalOp),
    .stateOut(stateOut)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: state visit order of one instruction, straight from the latency table.
  function automatic iq_t model_seq(logic [5:0] op);
    iq_t q;
    q = '{1, 2, 3};
    case (op)
      OPC_R:            q = {q, 4, 5};
      OPC_LW:           q = {q, 6, 7, 8, 9};
      OPC_SW:           q = {q, 6, 10};
      OPC_BEQ, OPC_BNE: q = {q, 11};
      OPC_J:            q = {q, 12};
      OPC_ADDI:         q = {q, 13, 14};
      default:          q = {q, 15};
    endcase
    return q;
  endfunction

  // Reference: what each state must drive.
  function automatic out_t model_out(int st, bit z, bit bne);
    out_t o;
    o = '0;
    o.alu_op = 2'b11;
    case (st)
      1:  o.mem_read = 1'b1;
      2:  begin o.mem_read = 1; o.ir_write = 1; o.alu_src_b = 2'b01; o.alu_op = 2'b00; o.pc_write = 1; end
      3:  begin o.alu_src_b = 2'b11; o.alu_op = 2'b00; end
      4:  begin o.alu_src_a = 1; o.alu_op = 2'b01; end
      5:  begin o.reg_dst = 1; o.reg_write = 1; end
      6, 13: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 2'b00; end
      7, 8: begin o.iord = 1; o.mem_read = 1; end
      9:  begin o.mem_to_reg = 1; o.reg_write = 1; end
      10: begin o.iord = 1; o.mem_write = 1; end
      11: begin o.alu_src_a = 1; o.alu_op = 2'b10; o.pc_source = 2'b01; o.pc_write = bne ? !z : z; end
      12: begin o.pc_source = 2'b10; o.pc_write = 1; end
      14: o.reg_write = 1;
      15: o.illegal = 1;
      default: ;
    endcase
    return o;
  endfunction

  // Drive one cycle's inputs (called at posedge+1), log its expectation, advance.
  task automatic cycle(int st, logic [5:0] op, bit z, bit bne);
    opcode = op;
    zero   = z;
    sb.push_back({4'(st), model_out(st, z, bne)});
    @(posedge clk);
    #1;
  endtask

  // One instruction; opcode is real only where the FSM consults it, noise elsewhere.
  task automatic run_instr(logic [5:0] op, bit zb, bit abort_mw);
    iq_t        seq;
    logic [5:0] drv;
    bit         z;
    bit         bne;
    bne = (op == OPC_BNE);
    seq = model_seq(op);
    foreach (seq[i]) begin
      drv = (seq[i] == 3 || seq[i] == 6) ? op : 6'($urandom);
      z   = (seq[i] == 11) ? zb : 1'($urandom);
      if (abort_mw && seq[i] == 10) begin
        check("sw_memwrite_before_reset", 32'(MemWrite), 32'd1);
        reset_n = 1'b0;
        #1;
        check("sw_memwrite_after_reset", 32'(MemWrite), 32'd0);
        check("sw_state_after_reset", 32'(stateOut), 32'd0);
        cycle(0, drv, z, 1'b0);
        reset_n = 1'b1;
        cycle(0, 6'($urandom), 1'($urandom), 1'b0);
        return;
      end
      cycle(seq[i], drv, z, bne);
    end
  endtask

  // Monitor: one expectation per falling edge.
  initial begin
    rec_t exp_r;
    out_t act;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got no expectation at %0t", $time);
      end else begin
        exp_r = sb.pop_front();
        act = {ALUOp, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite,
               RegDst, MemToReg, ALUSrcA, ALUSrcB, PCSource, illegalOp};
        check("state", 32'(stateOut), 32'(exp_r.st));
        check($sformatf("outputs_st%0d", exp_r.st), 32'(act), 32'(exp_r.o));
      end
    end
  end

  // Stimulus.
  initial begin
    logic [5:0] legal[7];
    logic [5:0] bad;
    legal = '{OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_BNE, OPC_J, OPC_ADDI};
    reset_n = 1'b0;
    opcode  = 6'h00;
    zero    = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) cycle(0, 6'($urandom), 1'($urandom), 1'b0);
    reset_n = 1'b1;
    cycle(0, 6'($urandom), 1'($urandom), 1'b0);

    // Directed coverage of every opcode and both branch outcomes.
    run_instr(OPC_R,    1'b0, 1'b0);
    run_instr(OPC_LW,   1'b0, 1'b0);
    run_instr(OPC_SW,   1'b0, 1'b0);
    run_instr(OPC_BEQ,  1'b1, 1'b0);
    run_instr(OPC_BEQ,  1'b0, 1'b0);
    run_instr(OPC_BNE,  1'b1, 1'b0);
    run_instr(OPC_BNE,  1'b0, 1'b0);
    run_instr(OPC_J,    1'b0, 1'b0);
    run_instr(OPC_ADDI, 1'b0, 1'b0);

    // Random instruction stream.
    for (int n = 0; n < 60; n++)
      run_instr(legal[$urandom_range(0, 6)], 1'($urandom), 1'b0);

    // Asynchronous reset in the middle of a store.
    run_instr(OPC_SW, 1'b0, 1'b1);
    run_instr(OPC_LW, 1'b1, 1'b0);

    // Unsupported opcode: sticky ILLEGAL until reset.
    bad = 6'h3f;
    run_instr(bad, 1'b0, 1'b0);
    repeat (20) cycle(15, 6'($urandom), 1'($urandom), 1'b0);
    reset_n = 1'b0;
    #1;
    check("illegal_cleared_by_reset", 32'(illegalOp), 32'd0);
    check("state_reset_from_illegal", 32'(stateOut), 32'd0);
    cycle(0, 6'($urandom), 1'($urandom), 1'b0);
    reset_n = 1'b1;
    cycle(0, 6'($urandom), 1'($urandom), 1'b0);

    // Random illegal opcode after recovery.
    do bad = 6'($urandom); while (bad inside {legal});
    run_instr(bad, 1'b0, 1'b0);
    repeat (3) cycle(15, 6'($urandom), 1'($urandom), 1'b0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
